adc_spi_responder: RTL and testbench
====================================

// Module: adc_spi_responder
// PURPOSE
//   Synthesizable slave-side model of the 8-channel 12-bit serial ADC interface that the AD_Converter master drives.
//   It answers ADC_CS_N/ADC_SCLK/ADC_SADDR with ADC_SDAT frames built from eight parallel sample inputs.
//   Used for in-FPGA loopback of the visualizer front end, and as a stimulus source when the real ADC is absent.
//   ADC_SCLK and ADC_CS_N are oversampled in the CLOCK domain. The block has no clock derived from ADC_SCLK.
// PARAMETERS
//   SYNC_STAGES  2   synchronizer flops on ADC_SCLK, ADC_CS_N and ADC_SADDR (minimum 2)
//   DATA_W       12  sample width; frame length is fixed at 16 bits
// PORTS
//   CLOCK        in   1   system clock; all state changes on rising edge
//   RESET        in   1   asynchronous, active-high reset
//   ADC_SCLK     in   1   serial clock from master; idles high
//   ADC_CS_N     in   1   chip select from master, active low
//   ADC_SADDR    in   1   serial channel address (DIN) from master
//   ADC_SDAT     out  1   serial data (DOUT) to master
//   CH0..CH7     in   12  sample values served per channel (eight ports)
//   CUR_ADDR     out  3   channel converted in the current/next frame
//   FRAME_DONE   out  1   one-CLOCK pulse after 16th SCLK rise of a frame
//   FRAME_ABORT  out  1   one-CLOCK pulse when CS_N rises mid-frame
// BEHAVIOUR
//   Reset: ADC_SDAT=0, CUR_ADDR=0, FRAME_DONE=0, FRAME_ABORT=0.
//     Reset also clears the bit counter, the shift register and the address capture.
//   Synchronizer output is csn_s/sclk_s/din_s. Edges are detected as a one-cycle difference on the synced value.
//   Edges on the raw pins are acted on SYNC_STAGES+1 CLOCK cycles later.
//   ADC_SCLK must stay high and low for at least SYNC_STAGES+2 CLOCK cycles each.
//   State machine:
//     IDLE: csn_s=1, ADC_SDAT=0.
//       On csn_s fall: snapshot CH[CUR_ADDR] into shift word {4'b0000, sample}; ADC_SDAT=bit15 (0); bit_cnt=0; go SHIFT.
//     SHIFT: on each sclk_s rise: bit_cnt increments by 1.
//       At bit_cnt values 2, 3, 4 (before increment), din_s is captured into addr_nxt[2], [1], [0] (MSB first).
//     SHIFT: on each sclk_s fall with bit_cnt in 1..15: shift word left by 1; ADC_SDAT = new bit15.
//       DOUT order: 4 leading zeros, then sample MSB..LSB.
//     SHIFT: on 16th sclk_s rise (bit_cnt 15->16):
//       CUR_ADDR<=addr_nxt; FRAME_DONE pulses 1 cycle; go WRAP.
//     WRAP: csn_s rise -> IDLE, ADC_SDAT=0.
//       sclk_s fall with csn_s low -> back-to-back frame: reload from CH[CUR_ADDR] (new value); ADC_SDAT=0; bit_cnt=0; SHIFT.
//   csn_s rise in SHIFT (bit_cnt<16): go IDLE, ADC_SDAT=0; FRAME_ABORT pulses; CUR_ADDR unchanged; addr_nxt discarded.
//   First frame after reset or IDLE converts CUR_ADDR. CUR_ADDR is 0 after reset. Each frame's address applies to the following frame.
//   CHn changes after the snapshot do not affect the frame in flight.
//   Simultaneous csn_s rise and sclk_s edge in the same cycle: CS wins; the SCLK edge is ignored.
//   sclk_s edges while csn_s=1 are ignored.
//   RESET asserted mid-frame: immediate return to reset values; the next frame needs a fresh csn_s fall.
// TESTING
//   1 Assert RESET mid-frame, release it.
//     -> ADC_SDAT=0, CUR_ADDR=0, no pulses.
//     -> The next CS frame serves CH0.
//   2 Set CH0=12'hA5C, CH3=12'h123. Run a frame with SADDR bits 2..4 = 0,1,1.
//     -> Master reads 16'h0A5C; FRAME_DONE pulses once; CUR_ADDR=3.
//     Run a second frame.
//     -> Master reads 16'h0123.
//   3 Hold CS_N low for 3 back-to-back frames with addresses 7, 1, 5, with CH7=12'hFFF and CH1=12'h001.
//     -> Reads are CH[0], 16'h0FFF, 16'h0001.
//     -> 3 FRAME_DONE pulses; CUR_ADDR=5.
//   4 Raise CS_N after 8 SCLK rises with SADDR address 6.
//     -> FRAME_ABORT pulses once; CUR_ADDR unchanged.
//     -> The next full frame restarts at the leading-zero bits.
//   5 Change CH0 from 12'h800 to 12'h7FF after the CS fall.
//     -> Frame reads 16'h0800; the next frame reads 16'h07FF.
//   6 Run SCLK at CLOCK/8 against the AD_Converter master in loopback for 1000 frames with random CHn.
//     -> CH outputs of the master match CHn with zero mismatches.

Source files
------------

// File: rtl/adc_spi_responder.sv
// Slave-side responder for an 8-channel 12-bit serial ADC: serves CHn samples on ADC_SDAT.
// All pins are oversampled in the CLOCK domain; no clock is derived from ADC_SCLK.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              ADC_SCLK,
  input  logic              ADC_CS_N,
  input  logic              ADC_SADDR,
  output logic              ADC_SDAT,
  input  logic [DATA_W-1:0] CH0,
  input  logic [DATA_W-1:0] CH1,
  input  logic [DATA_W-1:0] CH2,
  input  logic [DATA_W-1:0] CH3,
  input  logic [DATA_W-1:0] CH4,
  input  logic [DATA_W-1:0] CH5,
  input  logic [DATA_W-1:0] CH6,
  input  logic [DATA_W-1:0] CH7,
  output logic [2:0]        CUR_ADDR,
  output logic              FRAME_DONE,
  output logic              FRAME_ABORT
);

  localparam int PAD_W = 16 - DATA_W;

  typedef enum logic [1:0] {IDLE, SHIFT, WRAP} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csn_sync_q, csn_sync_d;
  logic [SYNC_STAGES-1:0] din_sync_q, din_sync_d;
  logic                   sclk_p_q, sclk_p_d;
  logic                   csn_p_q, csn_p_d;

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [2:0]  addr_nxt_q, addr_nxt_d;
  logic [2:0]  cur_addr_q, cur_addr_d;
  logic        sdat_q, sdat_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;

  logic              sclk_s, csn_s, din_s;
  logic              sclk_rise, sclk_fall, csn_rise, csn_fall;
  logic [DATA_W-1:0] sample;
  logic [15:0]       load_word;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign csn_s  = csn_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_p_q;
  assign sclk_fall = ~sclk_s & sclk_p_q;
  assign csn_rise  = csn_s & ~csn_p_q;
  assign csn_fall  = ~csn_s & csn_p_q;

  always_comb begin
    case (cur_addr_q)
      3'd0:    sample = CH0;
      3'd1:    sample = CH1;
      3'd2:    sample = CH2;
      3'd3:    sample = CH3;
      3'd4:    sample = CH4;
      3'd5:    sample = CH5;
      3'd6:    sample = CH6;
      default: sample = CH7;
    endcase
  end

  assign load_word = {{PAD_W{1'b0}}, sample};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], ADC_SCLK};
    csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0], ADC_CS_N};
    din_sync_d  = {din_sync_q[SYNC_STAGES-2:0], ADC_SADDR};
    sclk_p_d    = sclk_s;
    csn_p_d     = csn_s;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_nxt_d = addr_nxt_q;
    cur_addr_d = cur_addr_q;
    sdat_d     = sdat_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;

    case (state_q)
      IDLE: begin
        sdat_d = 1'b0;
        if (csn_fall) begin
          shift_d    = load_word;
          sdat_d     = load_word[15];
          bit_cnt_d  = 5'd0;
          addr_nxt_d = 3'd0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        // CS rise outranks any SCLK edge seen in the same cycle
        if (csn_rise) begin
          sdat_d  = 1'b0;
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise) begin
          case (bit_cnt_q)
            5'd2:    addr_nxt_d[2] = din_s;
            5'd3:    addr_nxt_d[1] = din_s;
            5'd4:    addr_nxt_d[0] = din_s;
            default: ;
          endcase
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd15) begin
            cur_addr_d = addr_nxt_q;
            done_d     = 1'b1;
            state_d    = WRAP;
          end
        end else if (sclk_fall && (bit_cnt_q != 5'd0) && (bit_cnt_q <= 5'd15)) begin
          shift_d = {shift_q[14:0], 1'b0};
          sdat_d  = shift_q[14];
        end
      end
      WRAP: begin
        if (csn_rise) begin
          sdat_d  = 1'b0;
          state_d = IDLE;
        end else if (sclk_fall && !csn_s) begin
          // back-to-back frame: CUR_ADDR already holds the new channel
          shift_d    = load_word;
          sdat_d     = 1'b0;
          bit_cnt_d  = 5'd0;
          addr_nxt_d = 3'd0;
          state_d    = SHIFT;
        end
      end
      default: begin
        sdat_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      sclk_sync_q <= '1;
      csn_sync_q  <= '1;
      din_sync_q  <= '0;
      sclk_p_q    <= 1'b1;
      csn_p_q     <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= 5'd0;
      shift_q     <= 16'd0;
      addr_nxt_q  <= 3'd0;
      cur_addr_q  <= 3'd0;
      sdat_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      csn_sync_q  <= csn_sync_d;
      din_sync_q  <= din_sync_d;
      sclk_p_q    <= sclk_p_d;
      csn_p_q     <= csn_p_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_nxt_q  <= addr_nxt_d;
      cur_addr_q  <= cur_addr_d;
      sdat_q      <= sdat_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
    end
  end

  assign ADC_SDAT    = sdat_q;
  assign CUR_ADDR    = cur_addr_q;
  assign FRAME_DONE  = done_q;
  assign FRAME_ABORT = abort_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: a master model drives CS/SCLK/SADDR and reads SDAT.
module tb_adc_spi_responder;

  localparam int H = 6;  // SCLK half period in CLOCK cycles

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        ADC_SCLK, ADC_CS_N, ADC_SADDR;
  logic        ADC_SDAT;
  logic [11:0] ch [8];
  logic [2:0]  CUR_ADDR;
  logic        FRAME_DONE, FRAME_ABORT;

  int total = 0;
  int bad   = 0;
  int done_cnt  = 0;
  int abort_cnt = 0;

  adc_spi_responder #(.SYNC_STAGES(2), .DATA_W(12)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .ADC_SCLK(ADC_SCLK), .ADC_CS_N(ADC_CS_N), .ADC_SADDR(ADC_SADDR), .ADC_SDAT(ADC_SDAT),
    .CH0(ch[0]), .CH1(ch[1]), .CH2(ch[2]), .CH3(ch[3]),
    .CH4(ch[4]), .CH5(ch[5]), .CH6(ch[6]), .CH7(ch[7]),
    .CUR_ADDR(CUR_ADDR), .FRAME_DONE(FRAME_DONE), .FRAME_ABORT(FRAME_ABORT)
  );

  always #5 CLOCK = ~CLOCK;

  always @(negedge CLOCK) begin
    if (FRAME_DONE)  done_cnt  <= done_cnt + 1;
    if (FRAME_ABORT) abort_cnt <= abort_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  typedef struct {
    logic        b2b;
    logic [2:0]  addr;
    logic [15:0] exp_rd;
    logic [2:0]  exp_cur;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic cs_fall();
    ADC_CS_N = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_rise();
    ADC_CS_N = 1'b1;
    wait_clk(2*H);
  endtask

  // n SCLK periods; bit i is sampled on rise i+1, address bits ride on rises 3..5
  task automatic clocks(input logic [2:0] addr, input int n, output logic [15:0] rd);
    rd = 16'd0;
    for (int i = 0; i < n; i++) begin
      ADC_SCLK = 1'b0;
      case (i)
        2:       ADC_SADDR = addr[2];
        3:       ADC_SADDR = addr[1];
        4:       ADC_SADDR = addr[0];
        default: ADC_SADDR = 1'b0;
      endcase
      wait_clk(H);
      ADC_SCLK = 1'b1;
      rd[15-i] = ADC_SDAT;
      wait_clk(H);
    end
    ADC_SADDR = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    int d0, a0;

    vecs[0] = '{1'b0, 3'd3, 16'h0A5C, 3'd3};
    vecs[1] = '{1'b0, 3'd0, 16'h0123, 3'd0};
    vecs[2] = '{1'b0, 3'd7, 16'h0A5C, 3'd7};
    vecs[3] = '{1'b1, 3'd1, 16'h0FFF, 3'd1};
    vecs[4] = '{1'b1, 3'd5, 16'h0001, 3'd5};
    vecs[5] = '{1'b0, 3'd2, 16'h0555, 3'd2};
    vecs[6] = '{1'b0, 3'd0, 16'h0222, 3'd0};

    ch[0] = 12'hA5C; ch[1] = 12'h001; ch[2] = 12'h222; ch[3] = 12'h123;
    ch[4] = 12'h444; ch[5] = 12'h555; ch[6] = 12'h666; ch[7] = 12'hFFF;
    RESET = 1'b1; ADC_CS_N = 1'b1; ADC_SCLK = 1'b1; ADC_SADDR = 1'b0;

    wait_clk(3);
    chk("rst_sdat",  16'(ADC_SDAT),    16'd0);
    chk("rst_cur",   16'(CUR_ADDR),    16'd0);
    chk("rst_done",  16'(FRAME_DONE),  16'd0);
    chk("rst_abort", 16'(FRAME_ABORT), 16'd0);
    RESET = 1'b0;
    wait_clk(5);

    for (int v = 0; v < 7; v++) begin
      d0 = done_cnt; a0 = abort_cnt;
      if (!vecs[v].b2b) begin
        if (!ADC_CS_N) cs_rise();
        cs_fall();
      end
      clocks(vecs[v].addr, 16, rd);
      chk($sformatf("vec%0d_rd", v),    rd,                      vecs[v].exp_rd);
      chk($sformatf("vec%0d_cur", v),   16'(CUR_ADDR),           16'(vecs[v].exp_cur));
      chk($sformatf("vec%0d_done", v),  16'(done_cnt - d0),      16'd1);
      chk($sformatf("vec%0d_abort", v), 16'(abort_cnt - a0),     16'd0);
    end
    cs_rise();

    // abort after 8 rises with address 6
    d0 = done_cnt; a0 = abort_cnt;
    cs_fall();
    clocks(3'd6, 8, rd);
    cs_rise();
    chk("abort_pulse", 16'(abort_cnt - a0), 16'd1);
    chk("abort_done",  16'(done_cnt - d0),  16'd0);
    chk("abort_cur",   16'(CUR_ADDR),       16'd0);
    chk("abort_sdat",  16'(ADC_SDAT),       16'd0);
    cs_fall();
    clocks(3'd0, 16, rd);
    chk("post_abort_rd", rd, 16'h0A5C);
    cs_rise();

    // channel change after snapshot
    ch[0] = 12'h800;
    cs_fall();
    ch[0] = 12'h7FF;
    clocks(3'd0, 16, rd);
    chk("snap_rd", rd, 16'h0800);
    cs_rise();
    cs_fall();
    clocks(3'd4, 16, rd);
    chk("snap_next_rd", rd, 16'h07FF);
    chk("snap_cur",     16'(CUR_ADDR), 16'd4);
    cs_rise();

    // reset mid-frame
    cs_fall();
    clocks(3'd6, 6, rd);
    d0 = done_cnt; a0 = abort_cnt;
    RESET = 1'b1;
    ADC_CS_N = 1'b1;
    wait_clk(2);
    chk("mrst_sdat", 16'(ADC_SDAT), 16'd0);
    chk("mrst_cur",  16'(CUR_ADDR), 16'd0);
    wait_clk(3);
    RESET = 1'b0;
    wait_clk(10);
    chk("mrst_done",  16'(done_cnt - d0),  16'd0);
    chk("mrst_abort", 16'(abort_cnt - a0), 16'd0);
    chk("mrst_cur2",  16'(CUR_ADDR),       16'd0);
    cs_fall();
    clocks(3'd0, 16, rd);
    chk("mrst_next_rd", rd, 16'h07FF);
    cs_rise();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
